// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction-fetch front end.
//   word_t / addr_t   : 32-bit instruction word and byte address
//   fetch_entry_t     : one queued instruction with its PC
//   ifq_state_t       : fetch FSM states (RUN issues, DRAIN drops stale data)
//   INST_BYTES        : fetch PC increment per instruction
package ifetch_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    word_t inst;
    addr_t pc;
  } fetch_entry_t;

  typedef enum logic {RUN, DRAIN} ifq_state_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: imem request/response, redirect and decode channel.
//   master : the fetch unit (drives imem requests and the decode channel)
//   slave  : the environment (memory, branch unit, decoder)
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  addr_t imem_req_addr;
  logic  imem_rsp_valid;
  word_t imem_rsp_data;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  inst_valid;
  logic  inst_ready;
  word_t inst_data;
  addr_t inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// sync_fifo: synchronous FIFO with asynchronous active-low reset and flush.
//   clk, rst_n          : clock, async active-low reset
//   flush               : empties the FIFO; overrides push and pop
//   push, push_data     : write one entry
//   pop                 : drop the head entry (ignored when empty)
//   pop_data            : head entry, zero when empty (0-cycle read)
//   empty, full, count  : occupancy status
// DEPTH need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign do_push  = push && !flush;
  assign do_pop   = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end.
//   clk, rst_n : clock, async active-low reset
//   bus        : master side of ifetch_queue_if
//                imem_req_*  word read requests at the fetch PC
//                imem_rsp_*  in-order read data, always accepted
//                redirect_*  restart fetch at a new PC, flushing the queue
//                inst_*      queue head towards decode (valid/ready)
// A queue slot is reserved for every in-flight request, so responses never
// overflow. Requests in flight at a redirect are counted in `discard` and
// their responses dropped in DRAIN.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter addr_t       RESET_PC  = '0
) (
  input logic           clk,
  input logic           rst_n,
  ifetch_queue_if.master bus
);
  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTST + 1);

  ifq_state_t    state_q, state_nxt;
  addr_t         fetch_pc;
  logic [OW-1:0] outst, discard, redir_discard;
  logic          fire, discarding, rsp_take;

  fetch_entry_t   q_head;
  logic           q_empty, q_full;
  logic [QCW-1:0] q_count;
  addr_t          tag_pc;
  logic           tag_empty, tag_full;
  logic [OW-1:0]  tag_count;

  assign fire       = bus.imem_req_valid && bus.imem_req_ready;
  assign discarding = (discard != '0);
  assign rsp_take   = bus.imem_rsp_valid && !discarding;
  // Everything still owed by memory after this cycle becomes stale: a
  // request firing now adds one, a response arriving now removes one.
  assign redir_discard = discard + outst + OW'(fire) - OW'(bus.imem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (bus.redirect_valid)
      state_nxt = (redir_discard != '0) ? DRAIN : RUN;
    else if (state_q == DRAIN && bus.imem_rsp_valid && discard == OW'(1))
      state_nxt = RUN;
  end

  always_comb begin
    bus.imem_req_valid = 1'b0;
    if (rst_n && state_q == RUN &&
        32'(outst) < MAX_OUTST &&
        32'(q_count) + 32'(outst) < DEPTH)
      bus.imem_req_valid = 1'b1;
  end

  assign bus.imem_req_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~addr_t'(INST_BYTES - 1);
      outst    <= '0;
      discard  <= redir_discard;
    end else begin
      if (fire) fetch_pc <= fetch_pc + INST_BYTES;
      outst <= outst + OW'(fire) - OW'(rsp_take);
      if (discarding && bus.imem_rsp_valid) discard <= discard - 1'b1;
    end
  end

  sync_fifo #(.T(addr_t), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (fire),
    .push_data (fetch_pc),
    .pop       (rsp_take),
    .pop_data  (tag_pc),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (rsp_take),
    .push_data ('{inst: bus.imem_rsp_data, pc: tag_pc}),
    .pop       (bus.inst_valid && bus.inst_ready),
    .pop_data  (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  assign bus.inst_valid = !q_empty;
  assign bus.inst_data  = q_head.inst;
  assign bus.inst_pc    = q_head.pc;

  rsp_unexpected: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (outst != '0 || discard != '0));
  rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_take |-> (!q_full && !tag_empty));
  tag_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (tag_count == outst) && !(fire && tag_full));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam addr_t       RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    addr_t addr;
    int    due;
  } pend_t;

  pend_t pend[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_due = 0;
  int    lat_min = 1, lat_max = 1;
  int    ready_pct = 100, iready_pct = 100;
  int    max_seen = 0;
  int    fires = 0, pops = 0;
  addr_t exp_pc, req_exp, last_pop_pc;
  bit    redirect_prev = 0;
  bit    arm_fire = 0, arm_pop = 0, wrap_seen = 0;
  addr_t first_fire, first_pop;

  // Memory contents: a fixed scramble of the address, so data/PC pairing is checkable.
  function automatic word_t mem_word(input addr_t a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_pc        = RESET_PC;
    req_exp       = RESET_PC;
    last_due      = cyc;
    redirect_prev = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid",  {31'b0, bus.imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, bus.inst_valid},     32'd0);
    check("rst_inst_data",  bus.inst_data,               32'd0);
    check("rst_inst_pc",    bus.inst_pc,                 32'd0);
    check("rst_req_addr",   bus.imem_req_addr,           RESET_PC);
  endtask

  // Called at posedge+1; leaves time at the next posedge+1.
  task automatic step(input bit redir, input addr_t rpc);
    bit    fire, rsp;
    int    due;
    bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    bus.inst_ready     = ($urandom_range(0, 99) < iready_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #4;
    rsp = bus.imem_rsp_valid;
    if (redirect_prev) check("flush_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, req_exp);
    fire = bus.imem_req_valid && bus.imem_req_ready;
    if (fire) begin
      fires++;
      if (arm_fire) begin first_fire = bus.imem_req_addr; arm_fire = 0; end
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: bus.imem_req_addr, due: due});
      req_exp += 4;
      if (pend.size() > max_seen) max_seen = pend.size();
      check("outst_le_max", {31'b0, pend.size() <= MAX_OUTST}, 32'd1);
    end
    if (bus.inst_valid && bus.inst_ready && !redir) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst_data", bus.inst_data, mem_word(exp_pc));
      if (arm_pop) begin first_pop = bus.inst_pc; arm_pop = 0; end
      if (exp_pc == 32'h0 && last_pop_pc == 32'hFFFF_FFFC) wrap_seen = 1;
      last_pop_pc = exp_pc;
      exp_pc += 4;
      pops++;
    end
    if (rsp) void'(pend.pop_front());
    if (redir) begin
      exp_pc  = rpc & ~32'd3;
      req_exp = rpc & ~32'd3;
    end
    redirect_prev = redir;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic wait_outst(input int n);
    int k = 0;
    while (pend.size() != n && k < 50) begin step(1'b0, 32'h0); k++; end
    check("wait_outst_timeout", {31'b0, k < 50}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: streaming, 1-cycle memory, always ready
    lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100;
    arm_fire = 1; arm_pop = 1;
    run(20);
    check("t1_first_fire", first_fire, RESET_PC);
    check("t1_first_pop", first_pop, RESET_PC);
    check("t1_pops", {31'b0, pops >= 10}, 32'd1);

    // 2: decode stalled -> exactly DEPTH requests, then resume at 0x10
    do_reset();
    iready_pct = 0; fires = 0;
    run(20);
    check("t2_fires", fires, DEPTH);
    check("t2_req_valid_low", {31'b0, bus.imem_req_valid}, 32'd0);
    check("t2_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
    iready_pct = 100; arm_fire = 1;
    run(20);
    check("t2_resume_addr", first_fire, 32'h10);

    // 3: latency 3 hits the outstanding limit; then random latency/backpressure
    lat_min = 3; lat_max = 3; max_seen = 0;
    run(40);
    check("t3_max_outst", max_seen, MAX_OUTST);
    lat_min = 1; lat_max = 5; ready_pct = 60; iready_pct = 60;
    run(150);

    // 4: redirect with two in flight
    lat_min = 3; lat_max = 3; ready_pct = 100; iready_pct = 100;
    wait_outst(2);
    step(1'b1, 32'h100);
    arm_fire = 1; arm_pop = 1; first_fire = 32'hDEAD_BEEF; first_pop = 32'hDEAD_BEEF;
    run(30);
    check("t4_first_fire", first_fire, 32'h100);
    check("t4_first_pop", first_pop, 32'h100);

    // 5: second redirect while draining
    lat_min = 4; lat_max = 4;
    wait_outst(2);
    step(1'b1, 32'h100);
    step(1'b1, 32'h200);
    arm_fire = 1; arm_pop = 1; first_fire = 32'hDEAD_BEEF; first_pop = 32'hDEAD_BEEF;
    run(30);
    check("t5_first_fire", first_fire, 32'h200);
    check("t5_first_pop", first_pop, 32'h200);

    // 6: async reset mid-stream, restart at RESET_PC, then PC wrap
    lat_min = 1; lat_max = 2;
    run(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    bus.imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    last_due = cyc;
    arm_fire = 1; arm_pop = 1; first_fire = 32'hDEAD_BEEF; first_pop = 32'hDEAD_BEEF;
    run(15);
    check("t6_restart_fire", first_fire, RESET_PC);
    check("t6_restart_pop", first_pop, RESET_PC);
    step(1'b1, 32'hFFFF_FFFB);
    arm_pop = 1; first_pop = 32'hDEAD_BEEF; wrap_seen = 0;
    run(25);
    check("t6_wrap_first_pop", first_pop, 32'hFFFF_FFF8);
    check("t6_wrap_seen", {31'b0, wrap_seen}, 32'd1);

    // random redirects under random latency/backpressure
    lat_min = 1; lat_max = 4; ready_pct = 70; iready_pct = 70;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 14) == 0) step(1'b1, $urandom);
      else                            step(1'b0, 32'h0);
    end
    check("rand_progress", {31'b0, pops > 20}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
